// File: rtl/mimc_round_ctrl.sv
// MiMC round controller: sequences key/constant adds and an external x^5 stage per round.
// Optional MIMC_FINAL_KEY_ADD_EN adds the key once more to the final output.
module mimc_round_ctrl #(
  parameter int                N_BITS   = 254,
  parameter logic [N_BITS-1:0] PRIME    = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                N_ROUNDS = 110,
  parameter int                RW       = $clog2(N_ROUNDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] x_in,
  input  logic [N_BITS-1:0] key,
  output logic [RW-1:0]     round_idx,
  input  logic [N_BITS-1:0] round_const,
  output logic [N_BITS-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              pow_rst,
  output logic              pow_en,
  output logic [N_BITS-1:0] pow_base,
  input  logic [N_BITS-1:0] pow_result,
  input  logic              pow_done
);

  typedef enum logic [3:0] {
    IDLE, LOAD, ADD_KEY, ADD_CONST, POW_RST, POW_GUARD, POW_WAIT, CAPTURE, FINAL, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] x_q, x_d, k_q, k_d, t_q, t_d, result_q, result_d, pow_base_q, pow_base_d;
  logic [RW-1:0]     round_idx_q, round_idx_d;
  logic              guard_q, guard_d;
  logic              busy_q, busy_d, done_q, done_d, pow_rst_q, pow_rst_d, pow_en_q, pow_en_d;

  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
    return s[N_BITS-1:0];
  endfunction

  function automatic logic [N_BITS-1:0] reduce(input logic [N_BITS-1:0] a);
    return (a >= PRIME) ? a - PRIME : a;
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    k_d         = k_q;
    t_d         = t_q;
    result_d    = result_q;
    round_idx_d = round_idx_q;
    guard_d     = guard_q;
    pow_base_d  = pow_base_q;
    case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD: begin
        x_d         = reduce(x_in);
        k_d         = reduce(key);
        round_idx_d = '0;
        state_d     = ADD_KEY;
      end
      ADD_KEY: begin
        t_d     = mod_add(x_q, k_q);
        state_d = ADD_CONST;
      end
      ADD_CONST: begin
        t_d     = mod_add(t_q, round_const);
        state_d = POW_RST;
      end
      POW_RST: begin
        guard_d = 1'b0;
        state_d = POW_GUARD;
      end
      // The stage's done flag is stale right after its reset, so wait blind for two cycles.
      POW_GUARD: begin
        guard_d = 1'b1;
        if (guard_q) state_d = POW_WAIT;
      end
      POW_WAIT:  if (pow_done) state_d = CAPTURE;
      CAPTURE: begin
        x_d = pow_result;
        if (round_idx_q < RW'(N_ROUNDS - 1)) begin
          round_idx_d = round_idx_q + RW'(1);
          state_d     = ADD_KEY;
        end else begin
          state_d     = FINAL;
        end
      end
      FINAL: begin
`ifdef MIMC_FINAL_KEY_ADD_EN
        result_d = mod_add(x_q, k_q);
`else
        result_d = x_q;
`endif
        state_d  = DONE;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    pow_en_d  = (state_d == POW_GUARD) || (state_d == POW_WAIT);
    pow_rst_d = !pow_en_d;
    if (state_d == POW_RST) pow_base_d = t_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      k_q         <= '0;
      t_q         <= '0;
      result_q    <= '0;
      round_idx_q <= '0;
      guard_q     <= 1'b0;
      pow_base_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pow_rst_q   <= 1'b1;
      pow_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      k_q         <= k_d;
      t_q         <= t_d;
      result_q    <= result_d;
      round_idx_q <= round_idx_d;
      guard_q     <= guard_d;
      pow_base_q  <= pow_base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pow_rst_q   <= pow_rst_d;
      pow_en_q    <= pow_en_d;
    end
  end

  assign round_idx = round_idx_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pow_rst   = pow_rst_q;
  assign pow_en    = pow_en_q;
  assign pow_base  = pow_base_q;

endmodule
